// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// latches the fetched word for the decoder and selects the next PC.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  input  logic            stall,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic [XLEN-1:0] imemRdata,
  input  logic            imemValid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic            instrValid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic [31:0]     instret,
  output logic            trap
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, ERR} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            req_q;
  logic [31:0]     instret_q;
  logic            trap_q;

  logic [XLEN-1:0] pc_plus4_d;
  logic [XLEN-1:0] next_pc_d;
  logic            misaligned_d;

  // pc+4 wraps naturally at the top of the address space.
  always_comb begin
    pc_plus4_d   = pc_q + XLEN'(4);
    next_pc_d    = pcSrc ? pcTarget : pc_plus4_d;
    misaligned_d = |next_pc_d[1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      instret_q     <= '0;
      trap_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_q   <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          if (imemValid) begin
            instr_q       <= imemRdata;
            instr_valid_q <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= DECODE;
          end
        end
        DECODE: begin
          if (!stall) begin
            // A misaligned next PC is fatal: freeze pc/instret and park in ERR.
            if (misaligned_d) begin
              trap_q        <= 1'b1;
              instr_valid_q <= 1'b0;
              req_q         <= 1'b0;
              state_q       <= ERR;
            end else begin
              pc_q          <= next_pc_d;
              instret_q     <= instret_q + 32'd1;
              instr_valid_q <= 1'b0;
              req_q         <= 1'b1;
              state_q       <= FETCH;
            end
          end
        end
        ERR: begin
          trap_q        <= 1'b1;
          instr_valid_q <= 1'b0;
          req_q         <= 1'b0;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imemReq    = req_q;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign op         = instr_q[6:0];
  assign instrValid = instr_valid_q;
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4_d;
  assign instret    = instret_q;
  assign trap       = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, sequential fetch, branch,
// stall, misaligned trap, reset during fetch and PC wraparound.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemValid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        instrValid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instret;
  logic        trap;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pcSrc      (pcSrc),
    .pcTarget   (pcTarget),
    .stall      (stall),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .imemValid  (imemValid),
    .instr      (instr),
    .op         (op),
    .instrValid (instrValid),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .instret    (instret),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: called in the first FETCH cycle, returns w after lat cycles.
  task automatic do_fetch(input logic [31:0] w, input int lat);
    imemValid = 1'b0;
    repeat (lat) tick();
    imemRdata = w;
    imemValid = 1'b1;
    tick();
    imemValid = 1'b0;
    imemRdata = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imemReq); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", instrValid); end
    checks++; if (pc !== 32'h0 || instr !== 32'h0) begin failures++; $display("FAIL rst_pc_instr: got pc=%h instr=%h expected 0/0", pc, instr); end
    checks++; if (instret !== 32'h0 || trap !== 1'b0) begin failures++; $display("FAIL rst_cnt_trap: got instret=%h trap=%b expected 0/0", instret, trap); end
    reset_n = 1'b1;
    #1;
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL idle_req: got %b expected 0", imemReq); end
    tick();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin failures++; $display("FAIL first_req: got req=%b addr=%h expected 1/0", imemReq, imemAddr); end
  endtask

  task automatic test_sequential();
    do_fetch(32'h0000_0013, 1);
    checks++; if (instrValid !== 1'b1 || op !== 7'h13) begin failures++; $display("FAIL seq_capture: got valid=%b op=%h expected 1/13", instrValid, op); end
    checks++; if (pc !== 32'h0 || pcPlus4 !== 32'h4) begin failures++; $display("FAIL seq_pc: got pc=%h pcPlus4=%h expected 0/4", pc, pcPlus4); end
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL seq_decode_req: got %b expected 0", imemReq); end
    tick();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin failures++; $display("FAIL seq_next: got req=%b addr=%h expected 1/4", imemReq, imemAddr); end
    checks++; if (instret !== 32'd1 || instrValid !== 1'b0) begin failures++; $display("FAIL seq_instret: got instret=%0d valid=%b expected 1/0", instret, instrValid); end
  endtask

  task automatic test_branch();
    do_fetch(32'h0000_0013, 2);
    tick();
    checks++; if (imemAddr !== 32'h8 || instret !== 32'd2) begin failures++; $display("FAIL br_seq8: got addr=%h instret=%0d expected 8/2", imemAddr, instret); end
    pcSrc = 1'b1;
    pcTarget = 32'h0000_0100;
    tick();
    checks++; if (imemAddr !== 32'h8 || imemReq !== 1'b1) begin failures++; $display("FAIL br_ignore_fetch: got addr=%h req=%b expected 8/1", imemAddr, imemReq); end
    do_fetch(32'h0000_006F, 1);
    checks++; if (op !== 7'h6F || pc !== 32'h8) begin failures++; $display("FAIL br_capture: got op=%h pc=%h expected 6f/8", op, pc); end
    pcTarget = 32'h0000_0040;
    tick();
    checks++; if (imemAddr !== 32'h40 || instret !== 32'd3) begin failures++; $display("FAIL br_taken: got addr=%h instret=%0d expected 40/3", imemAddr, instret); end
    pcTarget = 32'h0000_0080;
    repeat (2) tick();
    checks++; if (imemAddr !== 32'h40) begin failures++; $display("FAIL br_target_late: got addr=%h expected 40", imemAddr); end
    pcSrc = 1'b0;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    do_fetch(32'h00A0_0093, 1);
    checks++; if (instrValid !== 1'b1 || instr !== 32'h00A0_0093) begin failures++; $display("FAIL st_capture: got valid=%b instr=%h expected 1/00a00093", instrValid, instr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr !== 32'h00A0_0093 || pc !== 32'h40 || instrValid !== 1'b1 || imemReq !== 1'b0 || instret !== 32'd3) begin
        failures++;
        $display("FAIL st_hold%0d: got instr=%h pc=%h valid=%b req=%b instret=%0d expected 00a00093/40/1/0/3", i, instr, pc, instrValid, imemReq, instret);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (imemAddr !== 32'h44 || imemReq !== 1'b1 || instret !== 32'd4) begin failures++; $display("FAIL st_release: got addr=%h req=%b instret=%0d expected 44/1/4", imemAddr, imemReq, instret); end
  endtask

  task automatic test_trap();
    do_fetch(32'h0000_006F, 1);
    pcSrc = 1'b1;
    pcTarget = 32'h0000_0042;
    tick();
    pcSrc = 1'b0;
    checks++; if (trap !== 1'b1 || instrValid !== 1'b0) begin failures++; $display("FAIL trap_set: got trap=%b valid=%b expected 1/0", trap, instrValid); end
    for (int i = 0; i < 10; i++) begin
      imemValid = i[0];
      imemRdata = 32'h1111_1113;
      tick();
      checks++;
      if (imemReq !== 1'b0 || pc !== 32'h44 || trap !== 1'b1 || instret !== 32'd4 || instrValid !== 1'b0) begin
        failures++;
        $display("FAIL trap_hold%0d: got req=%b pc=%h trap=%b instret=%0d valid=%b expected 0/44/1/4/0", i, imemReq, pc, trap, instret, instrValid);
      end
    end
    imemValid = 1'b0;
    imemRdata = 32'h0;
    reset_n = 1'b0;
    #1;
    checks++; if (trap !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL trap_clear: got trap=%b pc=%h expected 0/0", trap, pc); end
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin failures++; $display("FAIL mf_req: got req=%b addr=%h expected 1/0", imemReq, imemAddr); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL mf_async_drop: got %b expected 0", imemReq); end
    tick();
    tick();
    reset_n = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    imemValid = 1'b1;
    tick();
    imemValid = 1'b0;
    imemRdata = 32'h0;
    checks++; if (instrValid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL mf_late_ignored: got valid=%b instr=%h expected 0/0", instrValid, instr); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin failures++; $display("FAIL mf_restart: got req=%b addr=%h expected 1/0", imemReq, imemAddr); end
    do_fetch(32'h0000_0013, 1);
    checks++; if (instr !== 32'h0000_0013 || pc !== 32'h0 || instrValid !== 1'b1) begin failures++; $display("FAIL mf_refetch: got instr=%h pc=%h valid=%b expected 13/0/1", instr, pc, instrValid); end
  endtask

  task automatic test_wrap();
    pcSrc = 1'b1;
    pcTarget = 32'hFFFF_FFFC;
    tick();
    pcSrc = 1'b0;
    checks++; if (imemAddr !== 32'hFFFF_FFFC || instret !== 32'd1) begin failures++; $display("FAIL wr_jump: got addr=%h instret=%0d expected fffffffc/1", imemAddr, instret); end
    do_fetch(32'h0000_0013, 1);
    checks++; if (pcPlus4 !== 32'h0) begin failures++; $display("FAIL wr_plus4: got %h expected 0", pcPlus4); end
    tick();
    checks++; if (imemAddr !== 32'h0 || trap !== 1'b0 || instret !== 32'd2) begin failures++; $display("FAIL wr_advance: got addr=%h trap=%b instret=%0d expected 0/0/2", imemAddr, trap, instret); end
  endtask

  initial begin
    reset_n   = 1'b0;
    pcSrc     = 1'b0;
    pcTarget  = 32'h0;
    stall     = 1'b0;
    imemRdata = 32'h0;
    imemValid = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_trap();
    test_reset_mid_fetch();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
